// File: rtl/maq_regressiva.sv
// MM:SS BCD countdown timer: load, start/pause, 1 Hz decrement with borrow, expiry at 00:00.
// Optional MAQR_ALARME_EN adds maqr_alarme, held for ALARME_TICKS enable ticks after expiry.
module maq_regressiva #(
  parameter int ALARME_TICKS = 10
) (
  input  logic       maqr_clock,
  input  logic       maqr_reset_n,
  input  logic       maqr_enable,
  input  logic       maqr_carrega,
  input  logic [2:0] maqr_carga_min_msd,
  input  logic [3:0] maqr_carga_min_lsd,
  input  logic [2:0] maqr_carga_seg_msd,
  input  logic [3:0] maqr_carga_seg_lsd,
  input  logic       maqr_inicia,
  input  logic       maqr_para,
  output logic [2:0] maqr_min_msd,
  output logic [3:0] maqr_min_lsd,
  output logic [2:0] maqr_seg_msd,
  output logic [3:0] maqr_seg_lsd,
  output logic       maqr_contando,
  output logic       maqr_zero,
  output logic       maqr_expirou,
`ifdef MAQR_ALARME_EN
  output logic       maqr_erro_carga,
  output logic       maqr_alarme
`else
  output logic       maqr_erro_carga
`endif
);

  typedef enum logic [1:0] {OCIOSO, CONTANDO, PAUSADO, EXPIRADO} estado_t;

  typedef struct packed {
    logic [2:0] min_msd;
    logic [3:0] min_lsd;
    logic [2:0] seg_msd;
    logic [3:0] seg_lsd;
  } tempo_t;

  localparam tempo_t UM = tempo_t'(14'd1);

  estado_t st_q, st_d;
  tempo_t  t_q, t_d, carga, dec;
  logic    carga_ok, carga_valida, expirou_d, erro_d;

  assign carga    = '{maqr_carga_min_msd, maqr_carga_min_lsd, maqr_carga_seg_msd, maqr_carga_seg_lsd};
  assign carga_ok = (carga.seg_lsd <= 4'd9) && (carga.min_lsd <= 4'd9) &&
                    (carga.seg_msd <= 3'd5) && (carga.min_msd <= 3'd5);

  assign maqr_min_msd = t_q.min_msd;
  assign maqr_min_lsd = t_q.min_lsd;
  assign maqr_seg_msd = t_q.seg_msd;
  assign maqr_seg_lsd = t_q.seg_lsd;
  assign maqr_zero    = (t_q == '0);

  // Borrow chain; 00:00 is never decremented, so min_msd cannot wrap.
  always_comb begin
    dec = t_q;
    if (t_q.seg_lsd == 4'd0) begin
      dec.seg_lsd = 4'd9;
      if (t_q.seg_msd == 3'd0) begin
        dec.seg_msd = 3'd5;
        if (t_q.min_lsd == 4'd0) begin
          dec.min_lsd = 4'd9;
          dec.min_msd = t_q.min_msd - 3'd1;
        end else begin
          dec.min_lsd = t_q.min_lsd - 4'd1;
        end
      end else begin
        dec.seg_msd = t_q.seg_msd - 3'd1;
      end
    end else begin
      dec.seg_lsd = t_q.seg_lsd - 4'd1;
    end
  end

  // Priority carrega > para > inicia > enable; a request ignored in the
  // current state does not mask the lower-priority ones.
  always_comb begin
    st_d         = st_q;
    t_d          = t_q;
    expirou_d    = 1'b0;
    erro_d       = 1'b0;
    carga_valida = 1'b0;
    if (maqr_carrega && st_q != CONTANDO) begin
      if (carga_ok) begin
        t_d          = carga;
        st_d         = OCIOSO;
        carga_valida = 1'b1;
      end else begin
        erro_d = 1'b1;
      end
    end else if (maqr_para && st_q == CONTANDO) begin
      st_d = PAUSADO;
    end else if (maqr_inicia && ((st_q == OCIOSO && !maqr_zero) || st_q == PAUSADO)) begin
      st_d = CONTANDO;
    end else if (maqr_enable && st_q == CONTANDO) begin
      t_d = dec;
      if (t_q == UM) begin
        st_d      = EXPIRADO;
        expirou_d = 1'b1;
      end
    end
  end

  always_ff @(posedge maqr_clock or negedge maqr_reset_n) begin
    if (!maqr_reset_n) begin
      st_q            <= OCIOSO;
      t_q             <= '0;
      maqr_contando   <= 1'b0;
      maqr_expirou    <= 1'b0;
      maqr_erro_carga <= 1'b0;
    end else begin
      st_q            <= st_d;
      t_q             <= t_d;
      maqr_contando   <= (st_d == CONTANDO);
      maqr_expirou    <= expirou_d;
      maqr_erro_carga <= erro_d;
    end
  end

`ifdef MAQR_ALARME_EN
  localparam logic [7:0] TICKS = 8'(ALARME_TICKS);
  logic [7:0] alarme_cnt;
  logic [7:0] alarme_cnt_inc;
  assign alarme_cnt_inc = alarme_cnt + 8'd1;

  always_ff @(posedge maqr_clock or negedge maqr_reset_n) begin
    if (!maqr_reset_n) begin
      maqr_alarme <= 1'b0;
      alarme_cnt  <= '0;
    end else if (carga_valida) begin
      maqr_alarme <= 1'b0;
    end else if (expirou_d) begin
      maqr_alarme <= 1'b1;
      alarme_cnt  <= '0;
    end else if (st_q == EXPIRADO && maqr_enable && maqr_alarme) begin
      alarme_cnt <= alarme_cnt_inc;
      if (alarme_cnt_inc == TICKS) maqr_alarme <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_maq_regressiva.sv
// Directed bench for maq_regressiva; time shown as 16'hMMSS BCD.
module tb_maq_regressiva;
  logic       clk = 1'b0;
  logic       rst_n, en, carrega, inicia, para;
  logic [2:0] c_min_msd, c_seg_msd;
  logic [3:0] c_min_lsd, c_seg_lsd;
  logic [2:0] min_msd, seg_msd;
  logic [3:0] min_lsd, seg_lsd;
  logic       contando, zero, expirou, erro;
`ifdef MAQR_ALARME_EN
  logic       alarme;
`endif
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  maq_regressiva #(.ALARME_TICKS(3)) dut (
    .maqr_clock(clk), .maqr_reset_n(rst_n), .maqr_enable(en), .maqr_carrega(carrega),
    .maqr_carga_min_msd(c_min_msd), .maqr_carga_min_lsd(c_min_lsd),
    .maqr_carga_seg_msd(c_seg_msd), .maqr_carga_seg_lsd(c_seg_lsd),
    .maqr_inicia(inicia), .maqr_para(para),
    .maqr_min_msd(min_msd), .maqr_min_lsd(min_lsd), .maqr_seg_msd(seg_msd), .maqr_seg_lsd(seg_lsd),
    .maqr_contando(contando), .maqr_zero(zero), .maqr_expirou(expirou),
`ifdef MAQR_ALARME_EN
    .maqr_erro_carga(erro), .maqr_alarme(alarme)
`else
    .maqr_erro_carga(erro)
`endif
  );

  function automatic logic [15:0] tempo();
    return {1'b0, min_msd, min_lsd, 1'b0, seg_msd, seg_lsd};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Load value given as 16'hMMSS; raw nibbles allow out-of-range digits.
  task automatic load(input logic [15:0] v);
    c_min_msd = v[14:12]; c_min_lsd = v[11:8];
    c_seg_msd = v[6:4];   c_seg_lsd = v[3:0];
    carrega = 1'b1; step(); carrega = 1'b0;
  endtask

  task automatic start();
    inicia = 1'b1; step(); inicia = 1'b0;
  endtask

  task automatic pausa();
    para = 1'b1; step(); para = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      en = 1'b1; step(); en = 1'b0; step();
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 0; carrega = 0; inicia = 0; para = 0;
    c_min_msd = 0; c_min_lsd = 0; c_seg_msd = 0; c_seg_lsd = 0;
    #12;
    chk("rst_tempo", tempo(), 16'h0000);
    chk("rst_zero", 16'(zero), 16'h1);
    chk("rst_contando", 16'(contando), 16'h0);
    chk("rst_expirou", 16'(expirou), 16'h0);
    chk("rst_erro", 16'(erro), 16'h0);
    rst_n = 1'b1;
    step();

    // Asynchronous reset mid-count
    load(16'h0530); start(); tick(1);
    chk("pre_rst", tempo(), 16'h0529);
    #1 rst_n = 1'b0; #1;
    chk("async_rst_tempo", tempo(), 16'h0000);
    chk("async_rst_zero", 16'(zero), 16'h1);
    chk("async_rst_contando", 16'(contando), 16'h0);
    rst_n = 1'b1;
    step();

    // Full minute to expiry
    load(16'h0100); start();
    chk("contando_on", 16'(contando), 16'h1);
    tick(1);
    chk("0100_dec", tempo(), 16'h0059);
    tick(58);
    chk("at_0001", tempo(), 16'h0001);
    chk("no_early_exp", 16'(expirou), 16'h0);
    en = 1'b1; step(); en = 1'b0;
    chk("exp_tempo", tempo(), 16'h0000);
    chk("exp_pulse", 16'(expirou), 16'h1);
    chk("exp_zero", 16'(zero), 16'h1);
    chk("exp_contando", 16'(contando), 16'h0);
    step();
    chk("exp_pulse_end", 16'(expirou), 16'h0);
    tick(3);
    chk("exp_hold", tempo(), 16'h0000);
    start(); tick(1);
    chk("exp_inicia_ign", 16'(contando), 16'h0);

    // Borrow across all digits
    load(16'h1000); start(); tick(1);
    chk("borrow_min", tempo(), 16'h0959);
    pausa();
    load(16'h0010); start(); tick(1);
    chk("borrow_seg", tempo(), 16'h0009);
    pausa();

    // Pause with coincident enable
    load(16'h0530); start(); tick(3);
    chk("run3", tempo(), 16'h0527);
    para = 1'b1; en = 1'b1; step(); para = 1'b0; en = 1'b0;
    chk("para_en_tempo", tempo(), 16'h0527);
    chk("para_contando", 16'(contando), 16'h0);
    tick(2);
    chk("paused_hold", tempo(), 16'h0527);
    start(); tick(1);
    chk("resume", tempo(), 16'h0526);
    chk("resume_contando", 16'(contando), 16'h1);

    // Load while counting is ignored
    load(16'h0123);
    chk("load_ign_tempo", tempo(), 16'h0526);
    chk("load_ign_contando", 16'(contando), 16'h1);
    chk("load_ign_erro", 16'(erro), 16'h0);
    pausa();

    // Invalid loads
    load(16'h000C);
    chk("bad_seg_erro", 16'(erro), 16'h1);
    chk("bad_seg_tempo", tempo(), 16'h0526);
    step();
    chk("bad_erro_end", 16'(erro), 16'h0);
    load(16'h0060);
    chk("bad_segmsd_erro", 16'(erro), 16'h1);
    load(16'h6000);
    chk("bad_minmsd_erro", 16'(erro), 16'h1);
    chk("bad_minmsd_tempo", tempo(), 16'h0526);

    // carrega beats inicia
    inicia = 1'b1; load(16'h0315); inicia = 1'b0;
    chk("load_inicia_tempo", tempo(), 16'h0315);
    chk("load_inicia_cont", 16'(contando), 16'h0);
    tick(1);
    chk("ocioso_hold", tempo(), 16'h0315);

    // inicia at 00:00 ignored
    load(16'h0000); start();
    chk("zero_inicia", 16'(contando), 16'h0);

`ifdef MAQR_ALARME_EN
    load(16'h0001); start();
    en = 1'b1; step(); en = 1'b0;
    chk("alarme_set", 16'(alarme), 16'h1);
    step();
    tick(1); chk("alarme_t1", 16'(alarme), 16'h1);
    tick(1); chk("alarme_t2", 16'(alarme), 16'h1);
    tick(1); chk("alarme_t3", 16'(alarme), 16'h0);
    load(16'h0001); start();
    en = 1'b1; step(); en = 1'b0;
    chk("alarme_set2", 16'(alarme), 16'h1);
    load(16'h0200);
    chk("alarme_load_clr", 16'(alarme), 16'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/maq_regressiva.md
Name: maq_regressiva

Overview:
- MM:SS countdown timer in BCD (00:00 to 59:59). It is the downward counterpart of the clock's up-counting seconds/minutes stages.
- Loaded with a start time, started and paused by user controls, and decremented once per 1 Hz enable tick.
- Borrows across seconds and minutes digits.
- Flags expiry and stops at 00:00.
- Drives the same BCD display path as the clock counters.

Parameters:
ALARME_TICKS, 10, number of enable ticks the alarm output stays high after expiry (used only when MAQR_ALARME_EN is defined); legal range 1..255

Ports:
maqr_clock  input  1  system clock
maqr_reset_n  input  1  asynchronous active-low reset
maqr_enable  input  1  1 Hz tick, one clock wide; time base for decrement
maqr_carrega  input  1  load request, sampled each clock
maqr_carga_min_msd  input  3  load value, minutes tens
maqr_carga_min_lsd  input  4  load value, minutes units
maqr_carga_seg_msd  input  3  load value, seconds tens
maqr_carga_seg_lsd  input  4  load value, seconds units
maqr_inicia  input  1  start/resume request
maqr_para  input  1  pause request
maqr_min_msd  output  3  current minutes tens
maqr_min_lsd  output  4  current minutes units
maqr_seg_msd  output  3  current seconds tens
maqr_seg_lsd  output  4  current seconds units
maqr_contando  output  1  high while in CONTANDO
maqr_zero  output  1  combinational, high when all four digits are 0
maqr_expirou  output  1  one-clock pulse on transition to 00:00
maqr_erro_carga  output  1  one-clock pulse when a load is rejected

Behaviour:
- Reset is asynchronous, active-low. Reset values:
  - all digits 0
  - state OCIOSO
  - maqr_contando=0, maqr_expirou=0, maqr_erro_carga=0
  - maqr_zero=1
- States:
  - OCIOSO: idle, value loaded or zero
  - CONTANDO: counting down
  - PAUSADO: paused, value held
  - EXPIRADO: reached 00:00
- Priority within one clock: carrega > para > inicia > enable.
- Load:
  - Honoured in OCIOSO, PAUSADO and EXPIRADO; ignored in CONTANDO, with no error.
  - Valid when both lsd values <=9 (msd values are 3-bit, so <=5 is checked explicitly).
  - Valid load: digits take the load values on the next edge and state goes to OCIOSO.
  - Invalid load: digits and state unchanged; maqr_erro_carga pulses for 1 clock on the next edge.
- inicia:
  - OCIOSO with nonzero value, or PAUSADO: next state CONTANDO.
  - OCIOSO with value 00:00: ignored.
  - EXPIRADO: ignored.
- para: in CONTANDO, next state PAUSADO. A coincident enable is discarded, with no decrement. para is ignored in all other states.
- Decrement, applied in CONTANDO on an edge where maqr_enable=1:
  - seg_lsd 0 -> 9 with borrow, else seg_lsd-1
  - on borrow: seg_msd 0 -> 5 with borrow, else seg_msd-1
  - on borrow: min_lsd 0 -> 9 with borrow, else min_lsd-1
  - on borrow: min_msd-1. Never underflows, because 00:00 is never decremented.
- Expiry:
  - Applies to the decrement edge where the value goes from 00:01 to 00:00.
  - On that same edge the digits become 00:00, state goes to EXPIRADO and maqr_expirou is registered high.
  - maqr_expirou is visible for exactly the clock after the edge; it coincides with the first cycle the display shows 00:00.
- Outputs are registered, except maqr_zero, which is combinational from the digits.
- maqr_contando is registered and equals (state==CONTANDO).
- Reset mid-count: immediate return to reset values; any pending pulse is cleared.
- EXPIRADO holds 00:00 until a valid load.

Optional Feature:
- Macro MAQR_ALARME_EN.
- Defined:
  - Adds output port maqr_alarme (1 bit), reset 0.
  - Set on the expiry edge.
  - An internal 8-bit counter counts maqr_enable ticks in EXPIRADO.
  - maqr_alarme clears on the edge where the counter reaches ALARME_TICKS, or immediately on a valid load or reset.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset low mid-operation -> all digits 0, maqr_zero=1, maqr_contando=0, asynchronously, without a clock edge.
2. Load 01:00, inicia, 1 enable tick -> 00:59; 59 more ticks -> 00:00, maqr_expirou high for exactly 1 clock, state EXPIRADO; further ticks leave 00:00.
3. Load 10:00, inicia, 1 tick -> 09:59. Repeat from 00:10 -> 00:09. Confirms borrow across every digit boundary.
4. Load 05:30, inicia, 3 ticks -> 05:27. para and enable in the same clock -> stays 05:27, maqr_contando=0. Ticks while paused leave 05:27. inicia then 1 tick -> 05:26.
5. Load with seg_lsd=4'd12 -> maqr_erro_carga 1-clock pulse, digits unchanged. carrega while CONTANDO -> ignored. carrega+inicia in the same clock from OCIOSO -> loaded, state OCIOSO. inicia at 00:00 -> stays OCIOSO.
6. With MAQR_ALARME_EN and ALARME_TICKS=3: expire from 00:01 -> maqr_alarme high for 3 enable ticks then low; a valid load during the alarm clears it on the next edge.
